// File: rtl/waveform_pkg.sv
// Shared types and helpers for the waveform capture path.
// Holds the capture state encoding and sample-to-screen conversion.
package waveform_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } capState_t;

  localparam int FRAME_LEN_DEF   = 160;
  localparam int MAX_MAG_DEF     = 59;
  localparam int SCALE_SHIFT_DEF = 5;

  // |s| >> shift, saturated; wide math so the most negative input is safe
  function automatic int convert(
    input int s,
    input int shift,
    input int maxMag
  );
    longint absVal;
    longint scaled;
    absVal = (s < 0) ? -longint'(s) : longint'(s);
    scaled = absVal >>> shift;
    return (scaled > longint'(maxMag)) ? maxMag : int'(scaled);
  endfunction

endpackage

// File: rtl/waveform_capture_sample_ram.sv
// Frame buffer: one write port, one registered read port.
// Out-of-range reads return zero.
module sample_ram
  import waveform_pkg::*;
#(
  parameter int DEPTH  = FRAME_LEN_DEF,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // synchronous write
  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  // registered read, old data on same-address write
  always_ff @(posedge clk) begin
    if (reset)
      rdData <= '0;
    else if (rdAddr < ADDR_W'(DEPTH))
      rdData <= mem[rdAddr];
    else
      rdData <= '0;
  end

endmodule

// File: rtl/waveform_capture.sv
// Decimating, triggered capture of one screen frame of samples.
// Display reads the held frame and releases it with frame_done.
module waveform_capture
  import waveform_pkg::*;
#(
  parameter int SAMPLE_W    = 12,
  parameter int MAG_W       = 6,
  parameter int MAX_MAG     = MAX_MAG_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int DECIM_W     = 8,
  parameter int AUTO_TRIG   = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                hold,
  input  logic [7:0]          rd_addr,
  output logic                rd_sign,
  output logic [MAG_W-1:0]    rd_mag,
  output logic                frame_ready,
  input  logic                frame_done,
  output logic                triggered_auto
);

  localparam int ADDR_W = 8;
  localparam int TO_W   = $clog2(AUTO_TRIG + 1);

  capState_t state, nextState;

  logic [DECIM_W-1:0]         decimL, decimCnt;
  logic signed [SAMPLE_W-1:0] levelL, prevS, curS;
  logic                       prevValid, donePend;
  logic [TO_W-1:0]            toCnt;
  logic [ADDR_W-1:0]          wrAddr, wrIdx;
  logic                       accept, levelHit, timeHit;
  logic                       trig, we, lastCol, relFrame;
  logic                       convSign;
  logic [MAG_W-1:0]           convMag;
  logic [MAG_W:0]             ramOut;

  assign curS     = sample_in;
  assign convSign = curS[SAMPLE_W-1];
  assign convMag  = MAG_W'(convert(int'(curS), SCALE_SHIFT, MAX_MAG));

  assign accept   = sample_valid && (decimCnt == decimL)
                 && (state != READY);
  assign levelHit = prevValid && (prevS < levelL) && (curS >= levelL);
  assign timeHit  = (toCnt == TO_W'(AUTO_TRIG - 1));
  assign lastCol  = (wrAddr == ADDR_W'(FRAME_LEN - 1));
  assign relFrame = (frame_done || donePend) && !hold;

  assign frame_ready = (state == READY);
  assign rd_sign     = ramOut[MAG_W];
  assign rd_mag      = ramOut[MAG_W-1:0];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ARMED;
    else       state <= nextState;
  end

  // next state and write strobe
  always_comb begin
    nextState = state;
    we        = 1'b0;
    trig      = 1'b0;
    wrIdx     = wrAddr;
    unique case (state)
      ARMED: begin
        if (accept && (levelHit || timeHit)) begin
          trig      = 1'b1;
          we        = 1'b1;
          wrIdx     = '0;
          nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          we = 1'b1;
          if (lastCol) nextState = READY;
        end
      end
      READY: begin
        if (relFrame) nextState = ARMED;
      end
      default: nextState = ARMED;
    endcase
  end

  // arm-time latches, decimation, trigger history, write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      decimL         <= decim;
      levelL         <= trig_level;
      decimCnt       <= '0;
      toCnt          <= '0;
      prevS          <= '0;
      prevValid      <= 1'b0;
      donePend       <= 1'b0;
      wrAddr         <= '0;
      triggered_auto <= 1'b0;
    end else if (state == READY && nextState == ARMED) begin
      decimL    <= decim;
      levelL    <= trig_level;
      decimCnt  <= '0;
      toCnt     <= '0;
      prevValid <= 1'b0;
      donePend  <= 1'b0;
    end else begin
      if (sample_valid && state != READY)
        decimCnt <= (decimCnt == decimL) ? '0 : decimCnt + 1'b1;
      if (state == READY && frame_done && hold)
        donePend <= 1'b1;
      if (state == ARMED && accept) begin
        prevS     <= curS;
        prevValid <= 1'b1;
        toCnt     <= toCnt + 1'b1;
      end
      if (trig) begin
        triggered_auto <= !levelHit;
        wrAddr         <= ADDR_W'(1);
      end else if (state == CAPTURE && accept) begin
        wrAddr <= wrAddr + 1'b1;
      end
    end
  end

  sample_ram #(
    .DEPTH (FRAME_LEN),
    .ADDR_W(ADDR_W),
    .DATA_W(MAG_W + 1)
  ) uRam (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wrAddr(wrIdx),
    .wrData({convSign, convMag}),
    .rdAddr(rd_addr),
    .rdData(ramOut)
  );

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
Acquisition-side producer for the oscilloscope display path. It takes signed ADC samples, decimates them, and waits for a rising-edge trigger crossing (or an auto-trigger timeout). It then fills a 160-entry frame buffer with sign/magnitude Y values pre-scaled to the 120-row screen. The display FSM reads the held frame column by column through a registered read port and releases it with a done pulse; pause holds the frame indefinitely.

Parameters:
SAMPLE_W, 12, width of signed two's-complement input sample
MAG_W, 6, width of output magnitude (value range 0..MAX_MAG)
MAX_MAG, 59, clamp limit for magnitude so that 60±mag stays within 1..119
SCALE_SHIFT, 5, arithmetic right-shift applied to each sample before clamp
FRAME_LEN, 160, samples per frame (one per screen column)
DECIM_W, 8, width of the decimation ratio input
AUTO_TRIG, 4096, decimated samples to wait in ARMED before forcing a trigger

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe; sample_in is valid
sample_in  in  SAMPLE_W  signed ADC sample
decim  in  DECIM_W  keep 1 of (decim+1) valid samples; sampled at arm time
trig_level  in  SAMPLE_W  signed trigger threshold; sampled at arm time
hold  in  1  pause request (active high, already debounced/inverted upstream)
rd_addr  in  8  column index requested by display
rd_sign  out  1  0 = positive, 1 = negative, for column rd_addr
rd_mag  out  MAG_W  clamped magnitude for column rd_addr
frame_ready  out  1  a complete frame is held and readable
frame_done  in  1  one-cycle pulse from display: frame consumed
triggered_auto  out  1  held frame was captured via timeout, not a level crossing

Behaviour:
- States: ARMED, CAPTURE, READY. Reset -> ARMED, with all counters 0, frame_ready=0, triggered_auto=0, rd_sign=0, rd_mag=0, prev-sample-valid flag cleared.
- Decimation: a counter advances on each sample_valid. A sample is accepted when counter==decim_latched, and the counter then returns to 0. decim=0 accepts every sample.
- Conversion of an accepted sample s:
  - sign = s[SAMPLE_W-1].
  - mag = |s| >>> SCALE_SHIFT, saturated to MAX_MAG.
  - |most negative| must not overflow; compute it in SAMPLE_W+1 bits.
- ARMED:
  - On entry, latch decim and trig_level, clear the timeout counter, and clear prev-valid.
  - Trigger when prev < level AND cur >= level, using signed compare on raw samples.
  - The first accepted sample after entry only loads prev and cannot trigger.
  - The timeout counter increments per accepted sample. When it reaches AUTO_TRIG, force a trigger and set triggered_auto=1. A level trigger clears triggered_auto.
  - The triggering sample is written at address 0. Go to CAPTURE with wr_addr=1.
- CAPTURE: each accepted sample is written at wr_addr, and wr_addr increments. After writing address FRAME_LEN-1, the next cycle enters READY and sets frame_ready=1. No wrap occurs and no samples are dropped within a frame.
- READY:
  - Samples are ignored; the buffer is frozen.
  - On frame_done && !hold, clear frame_ready next cycle and go to ARMED.
  - frame_done while hold=1 is remembered (pending flag), so release happens on the cycle hold falls.
  - hold has no effect in ARMED or CAPTURE.
- Read port: 1-cycle latency. rd_sign/rd_mag reflect the rd_addr presented on the previous edge and are valid in every state. Reads of an address being written in the same cycle return old data. rd_addr >= FRAME_LEN returns sign=0, mag=0.
- Simultaneous events:
  - frame_done outside READY is ignored.
  - A sample_valid coinciding with the READY->ARMED transition is not accepted.
- Reset mid-CAPTURE discards the partial frame, and frame_ready stays 0.

Decomposition:
- Package waveform_pkg: state encoding (ARMED/CAPTURE/READY), FRAME_LEN, MAX_MAG, SCALE_SHIFT defaults, and the convert function (signed sample -> {sign, mag}).
- One sub-module, sample_ram: simple dual-port 160 x (1+MAG_W) RAM with a synchronous write port and a registered read port, inferable to block RAM.

Test Plan:
- Ramp -100..+100 step 1, decim=0, level=0, SCALE_SHIFT=0 -> trigger on sample 0 (prev -1); frame holds 0..59 then saturates at mag=59 sign=0 from col 59 to 100; col 0 reads sign=0 mag=0.
- Constant -5, decim=0, AUTO_TRIG=4096 -> frame_ready rises after 4096+159 accepted samples; triggered_auto=1; all cols sign=1, mag=5 (SCALE_SHIFT=0).
- Square wave ±2000, decim=3, SCALE_SHIFT=5 -> exactly 1 of every 4 strobes stored; col 0 mag=59 sign=0 (2000>>5=62 clamps to 59); -2048 input reads mag=59 sign=1 with no overflow.
- READY with hold=1, pulse frame_done at t, drop hold at t+50 -> frame_ready deasserts the cycle after hold falls; sweeping rd_addr 0..159 returns an unchanged frame throughout.
- Assert reset at wr_addr=80 during CAPTURE -> frame_ready=0, state ARMED; the next capture produces a full 160-column frame.
- rd_addr=200 -> rd_sign=0, rd_mag=0 one cycle later; rd_addr=159 returns the last written sample.
